// File: rtl/reg_wb_arb.sv
// Writeback arbiter for three result sources (ALU, LOAD, MULDIV) feeding one
// register-file write port, plus a pending-write scoreboard for hazard checks.
module reg_wb_arb #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        REG_WB_ARB_CLK,
    input  logic        REG_WB_ARB_RST_N,
    input  logic [2:0]  REG_WB_ARB_valid,
    input  logic [4:0]  REG_WB_ARB_rd0,
    input  logic [4:0]  REG_WB_ARB_rd1,
    input  logic [4:0]  REG_WB_ARB_rd2,
    input  logic [31:0] REG_WB_ARB_data0,
    input  logic [31:0] REG_WB_ARB_data1,
    input  logic [31:0] REG_WB_ARB_data2,
    output logic [2:0]  REG_WB_ARB_ready,
    input  logic        REG_WB_ARB_issue_valid,
    input  logic [4:0]  REG_WB_ARB_issue_rd,
    output logic        REG_WB_ARB_issue_ready,
    input  logic [4:0]  REG_WB_ARB_adr1,
    input  logic [4:0]  REG_WB_ARB_adr2,
    output logic        REG_WB_ARB_busy1,
    output logic        REG_WB_ARB_busy2,
    output logic        REG_WB_ARB_wf_en,
    output logic [4:0]  REG_WB_ARB_wf_wa,
    output logic [31:0] REG_WB_ARB_wf_wd
);

    localparam int unsigned N_REQ = 3;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned N_REG = 32;

    logic [1:0]       rr_ptr_q;
    logic [N_REG-1:0] pending_q;
    logic [N_REG-1:0] pending_d;
    logic [N_REQ-1:0] grant;
    logic [1:0]       gidx;
    logic [1:0]       cand;
    logic             found;
    logic             accept;
    logic             commit;
    logic             issue_fire;
    logic [AW-1:0]    sel_rd;
    logic [DW-1:0]    sel_data;

    // Pick the winning requester: rotating after the last grant, or lowest index.
    always_comb begin
        found = 1'b0;
        gidx  = 2'd0;
        cand  = 2'd0;
        grant = '0;
        if (RR_EN != 0) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = 2'((32'(rr_ptr_q) + k) % N_REQ);
                if (!found && REG_WB_ARB_valid[cand]) begin
                    found = 1'b1;
                    gidx  = cand;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!found && REG_WB_ARB_valid[k]) begin
                    found = 1'b1;
                    gidx  = 2'(k);
                end
            end
        end
        if (found) begin
            grant = 3'(3'b001 << gidx);
        end
    end

    // Grant is suppressed while reset is held so nothing is accepted.
    always_comb begin
        REG_WB_ARB_ready = REG_WB_ARB_RST_N ? grant : '0;
        accept           = found && REG_WB_ARB_RST_N;
    end

    // Route the granted requester's destination and data.
    always_comb begin
        case (gidx)
            2'd0:    begin sel_rd = REG_WB_ARB_rd0; sel_data = REG_WB_ARB_data0; end
            2'd1:    begin sel_rd = REG_WB_ARB_rd1; sel_data = REG_WB_ARB_data1; end
            default: begin sel_rd = REG_WB_ARB_rd2; sel_data = REG_WB_ARB_data2; end
        endcase
        commit = accept && (sel_rd != '0);
    end

    // Hazard lookups; pending bit 0 is never set, so x0 always reads as free.
    always_comb begin
        REG_WB_ARB_issue_ready = (REG_WB_ARB_issue_rd == '0) || !pending_q[REG_WB_ARB_issue_rd];
        REG_WB_ARB_busy1       = pending_q[REG_WB_ARB_adr1];
        REG_WB_ARB_busy2       = pending_q[REG_WB_ARB_adr2];
        issue_fire             = REG_WB_ARB_issue_valid && REG_WB_ARB_issue_ready
                                 && (REG_WB_ARB_issue_rd != '0);
    end

    // Scoreboard next state: retire the write in flight, then record a new claim.
    always_comb begin
        pending_d = pending_q;
        if (REG_WB_ARB_wf_en) begin
            pending_d[REG_WB_ARB_wf_wa] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[REG_WB_ARB_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State and registered write port; reset drops any write in flight.
    always_ff @(posedge REG_WB_ARB_CLK or negedge REG_WB_ARB_RST_N) begin
        if (!REG_WB_ARB_RST_N) begin
            rr_ptr_q         <= 2'd2;
            pending_q        <= '0;
            REG_WB_ARB_wf_en <= 1'b0;
            REG_WB_ARB_wf_wa <= '0;
            REG_WB_ARB_wf_wd <= '0;
        end else begin
            if (accept && (RR_EN != 0)) begin
                rr_ptr_q <= gidx;
            end
            pending_q        <= pending_d;
            REG_WB_ARB_wf_en <= commit;
            REG_WB_ARB_wf_wa <= commit ? sel_rd : '0;
            REG_WB_ARB_wf_wd <= commit ? sel_data : '0;
        end
    end

endmodule

// File: tb/tb_reg_wb_arb.sv
// Bench for reg_wb_arb: one round-robin and one fixed-priority instance,
// directed scenarios followed by random traffic against a cycle model.
module tb_reg_wb_arb;

    logic clk;
    logic rst_n;

    logic [2:0]  valid [2];
    logic [4:0]  rd    [2][3];
    logic [31:0] data  [2][3];
    logic        iv    [2];
    logic [4:0]  ird   [2];
    logic [4:0]  a1    [2];
    logic [4:0]  a2    [2];

    logic [2:0]  rdy   [2];
    logic        irdy  [2];
    logic        b1    [2];
    logic        b2    [2];
    logic        wen   [2];
    logic [4:0]  wa    [2];
    logic [31:0] wd    [2];

    // Instance 0 is round-robin, instance 1 is fixed priority.
    for (genvar m = 0; m < 2; m++) begin : g_dut
        reg_wb_arb #(.RR_EN((m == 0) ? 1 : 0)) u_dut (
            .REG_WB_ARB_CLK         (clk),
            .REG_WB_ARB_RST_N       (rst_n),
            .REG_WB_ARB_valid       (valid[m]),
            .REG_WB_ARB_rd0         (rd[m][0]),
            .REG_WB_ARB_rd1         (rd[m][1]),
            .REG_WB_ARB_rd2         (rd[m][2]),
            .REG_WB_ARB_data0       (data[m][0]),
            .REG_WB_ARB_data1       (data[m][1]),
            .REG_WB_ARB_data2       (data[m][2]),
            .REG_WB_ARB_ready       (rdy[m]),
            .REG_WB_ARB_issue_valid (iv[m]),
            .REG_WB_ARB_issue_rd    (ird[m]),
            .REG_WB_ARB_issue_ready (irdy[m]),
            .REG_WB_ARB_adr1        (a1[m]),
            .REG_WB_ARB_adr2        (a2[m]),
            .REG_WB_ARB_busy1       (b1[m]),
            .REG_WB_ARB_busy2       (b2[m]),
            .REG_WB_ARB_wf_en       (wen[m]),
            .REG_WB_ARB_wf_wa       (wa[m]),
            .REG_WB_ARB_wf_wd       (wd[m])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model state per instance.
    logic [31:0] pend     [2];
    int          last     [2];
    logic        m_en     [2];
    logic [4:0]  m_wa     [2];
    logic [31:0] m_wd     [2];
    logic [2:0]  acc_mask [2];
    logic [31:0] nx_pend  [2];
    int          nx_last  [2];
    logic        nx_en    [2];
    logic [4:0]  nx_wa    [2];
    logic [31:0] nx_wd    [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input int m, input logic [2:0] v);
        int j;
        if (v == 3'b000) return -1;
        if (m == 1) begin
            for (int i = 0; i < 3; i++) if (v[i]) return i;
        end else begin
            for (int i = 1; i <= 3; i++) begin
                j = (last[m] + i) % 3;
                if (v[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pend[m]     = '0;
            last[m]     = 2;
            m_en[m]     = 1'b0;
            m_wa[m]     = '0;
            m_wd[m]     = '0;
            acc_mask[m] = '0;
        end
    endtask

    task automatic idle();
        for (int m = 0; m < 2; m++) begin
            valid[m] = '0;
            for (int i = 0; i < 3; i++) begin
                rd[m][i]   = '0;
                data[m][i] = '0;
            end
            iv[m]  = 1'b0;
            ird[m] = '0;
            a1[m]  = '0;
            a2[m]  = '0;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: compare every output with the model, then advance it on the edge.
    task automatic cycle();
        int         g;
        logic [2:0] er;
        logic       eir;
        logic [31:0] np;
        #1;
        for (int m = 0; m < 2; m++) begin
            g   = model_grant(m, valid[m]);
            er  = (g < 0) ? 3'b000 : 3'(3'b001 << g);
            eir = (ird[m] == 5'd0) || !pend[m][ird[m]];
            check($sformatf("m%0d ready", m), 32'(rdy[m]), 32'(er));
            check($sformatf("m%0d issue_ready", m), 32'(irdy[m]), 32'(eir));
            check($sformatf("m%0d busy1", m), 32'(b1[m]), 32'(pend[m][a1[m]]));
            check($sformatf("m%0d busy2", m), 32'(b2[m]), 32'(pend[m][a2[m]]));
            check($sformatf("m%0d wf_en", m), 32'(wen[m]), 32'(m_en[m]));
            if (m_en[m]) begin
                check($sformatf("m%0d wf_wa", m), 32'(wa[m]), 32'(m_wa[m]));
                check($sformatf("m%0d wf_wd", m), wd[m], m_wd[m]);
            end
            acc_mask[m] = er;
            np = pend[m];
            if (m_en[m]) np[m_wa[m]] = 1'b0;
            if (iv[m] && eir && ird[m] != 5'd0) np[ird[m]] = 1'b1;
            np[0] = 1'b0;
            nx_pend[m] = np;
            if (g >= 0) begin
                nx_en[m]   = (rd[m][g] != 5'd0);
                nx_wa[m]   = rd[m][g];
                nx_wd[m]   = data[m][g];
                nx_last[m] = g;
            end else begin
                nx_en[m]   = 1'b0;
                nx_wa[m]   = '0;
                nx_wd[m]   = '0;
                nx_last[m] = last[m];
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            pend[m] = nx_pend[m];
            last[m] = nx_last[m];
            m_en[m] = nx_en[m];
            m_wa[m] = nx_wa[m];
            m_wd[m] = nx_wd[m];
        end
        @(negedge clk);
    endtask

    // Hold reset for two edges; outputs must be quiet even with requests present.
    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        for (int m = 0; m < 2; m++) begin
            valid[m] = 3'b111;
            a1[m]    = 5'd3;
            a2[m]    = 5'd7;
        end
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst m%0d ready", m), 32'(rdy[m]), 32'd0);
            check($sformatf("rst m%0d wf_en", m), 32'(wen[m]), 32'd0);
            check($sformatf("rst m%0d wf_wa", m), 32'(wa[m]), 32'd0);
            check($sformatf("rst m%0d wf_wd", m), wd[m], 32'd0);
            check($sformatf("rst m%0d busy1", m), 32'(b1[m]), 32'd0);
            check($sformatf("rst m%0d busy2", m), 32'(b2[m]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        model_reset();
        do_reset();

        // Round-robin rotation with all three requesting continuously.
        valid[0]   = 3'b111;
        rd[0][0]   = 5'd1;  data[0][0] = 32'hA000_0001;
        rd[0][1]   = 5'd2;  data[0][1] = 32'hA000_0002;
        rd[0][2]   = 5'd3;  data[0][2] = 32'hA000_0003;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("rr_grant_seq", 32'(rdy[0]), 32'(3'b001 << (k % 3)));
            if (k >= 1) begin
                check("rr_wf_en", 32'(wen[0]), 32'd1);
                check("rr_wf_wa", 32'(wa[0]), 32'((k - 1) % 3 + 1));
            end
            cycle();
        end
        idle();
        cycle();

        // Fixed priority: requester 1 wins over 2 until it drops.
        valid[1] = 3'b110;
        rd[1][1] = 5'd4; data[1][1] = 32'h0000_0044;
        rd[1][2] = 5'd6; data[1][2] = 32'h0000_0066;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("fp_grant_1", 32'(rdy[1]), 32'h2);
            cycle();
        end
        valid[1] = 3'b100;
        settle();
        check("fp_grant_2", 32'(rdy[1]), 32'h4);
        cycle();
        idle();
        cycle();

        // Issue x5, then a LOAD commits to it; busy clears the cycle after the write.
        iv[0]  = 1'b1;
        ird[0] = 5'd5;
        settle();
        check("issue5_ready", 32'(irdy[0]), 32'd1);
        cycle();
        iv[0]      = 1'b0;
        a1[0]      = 5'd5;
        valid[0]   = 3'b010;
        rd[0][1]   = 5'd5;
        data[0][1] = 32'hDEAD_BEEF;
        settle();
        check("busy5_set", 32'(b1[0]), 32'd1);
        check("load_grant", 32'(rdy[0]), 32'h2);
        cycle();
        valid[0] = 3'b000;
        settle();
        check("load_wf_en", 32'(wen[0]), 32'd1);
        check("load_wf_wd", wd[0], 32'hDEAD_BEEF);
        check("busy5_during_wf", 32'(b1[0]), 32'd1);
        cycle();
        settle();
        check("busy5_cleared", 32'(b1[0]), 32'd0);
        check("load_wf_done", 32'(wen[0]), 32'd0);
        cycle();

        // WAW stall on x7, including the cycle where its commit is in flight.
        iv[0]  = 1'b1;
        ird[0] = 5'd7;
        cycle();
        valid[0]   = 3'b001;
        rd[0][0]   = 5'd7;
        data[0][0] = 32'h0000_0777;
        settle();
        check("waw_stall", 32'(irdy[0]), 32'd0);
        cycle();
        valid[0] = 3'b000;
        settle();
        check("commit7_wf_wa", 32'(wa[0]), 32'd7);
        check("waw_stall_commit", 32'(irdy[0]), 32'd0);
        cycle();
        settle();
        check("waw_released", 32'(irdy[0]), 32'd1);
        cycle();
        iv[0] = 1'b0;
        a1[0] = 5'd7;
        settle();
        check("reissue7_busy", 32'(b1[0]), 32'd1);
        cycle();
        idle();
        cycle();

        // Writeback to x0 is consumed without a register-file write.
        valid[0]   = 3'b001;
        rd[0][0]   = 5'd0;
        data[0][0] = 32'h0000_1234;
        settle();
        check("x0_grant", 32'(rdy[0]), 32'h1);
        cycle();
        valid[0] = 3'b000;
        settle();
        check("x0_no_write", 32'(wen[0]), 32'd0);
        cycle();

        // Reset between acceptance and write: the write and the claim are lost.
        iv[0]  = 1'b1;
        ird[0] = 5'd9;
        cycle();
        iv[0]      = 1'b0;
        valid[0]   = 3'b010;
        rd[0][1]   = 5'd9;
        data[0][1] = 32'h0000_CAFE;
        cycle();
        valid[0] = 3'b000;
        a1[0]    = 5'd9;
        settle();
        check("pre_rst_wf_en", 32'(wen[0]), 32'd1);
        check("pre_rst_busy9", 32'(b1[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_wf_en", 32'(wen[0]), 32'd0);
        check("rst_clear_busy9", 32'(b1[0]), 32'd0);
        do_reset();

        // Random traffic honouring the hold-until-accepted rule.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!valid[m][i] || acc_mask[m][i]) begin
                        valid[m][i] = 1'($urandom_range(0, 1));
                        rd[m][i]    = 5'($urandom_range(0, 7));
                        data[m][i]  = $urandom;
                    end
                end
                iv[m]  = 1'($urandom_range(0, 1));
                ird[m] = 5'($urandom_range(0, 7));
                a1[m]  = 5'($urandom_range(0, 7));
                a2[m]  = 5'($urandom_range(0, 7));
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wb_arb.md
REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1: 1 = round-robin grant, 0 = fixed priority (requester 0 highest, then 1, then 2).
REQ-002 The block SHALL have port REG_WB_ARB_CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port REG_WB_ARB_RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports REG_WB_ARB_valid[2:0], input, 3 bits: writeback request per requester (0 = ALU, 1 = LOAD, 2 = MULDIV).
REQ-005 The block SHALL have ports REG_WB_ARB_rd0/rd1/rd2, input, 5 bits each: destination register per requester.
REQ-006 The block SHALL have ports REG_WB_ARB_data0/data1/data2, input, 32 bits each: write data per requester.
REQ-007 The block SHALL have port REG_WB_ARB_ready[2:0], output, 3 bits: grant; a request is accepted in a cycle where valid and ready are both 1.
REQ-008 The block SHALL have ports REG_WB_ARB_issue_valid (input, 1), REG_WB_ARB_issue_rd (input, 5), and REG_WB_ARB_issue_ready (output, 1): an instruction claims a destination register.
REQ-009 The block SHALL have ports REG_WB_ARB_adr1 and REG_WB_ARB_adr2, input, 5 bits each: source registers to check.
REQ-010 The block SHALL have ports REG_WB_ARB_busy1 and REG_WB_ARB_busy2, output, 1 bit each: the source has a pending write.
REQ-011 The block SHALL have ports REG_WB_ARB_wf_en (1), REG_WB_ARB_wf_wa (5), and REG_WB_ARB_wf_wd (32), all outputs: register-file write port.

Function
REQ-012 ready SHALL be combinational: at most one bit set per cycle, and only for a requester with valid=1; ready SHALL be all-zero when no valid is set.
REQ-013 With RR_EN=1, the grant SHALL go to the first valid requester after the last-granted index, in order 0->1->2->0; the pointer SHALL update only on acceptance.
REQ-014 With RR_EN=0, the grant SHALL go to the lowest-index valid requester; the pointer SHALL be unused.
REQ-015 Requesters SHALL hold valid, rd, and data stable until accepted; the block SHALL NOT sample unaccepted requests.
REQ-016 An accepted request SHALL appear on the write port exactly 1 cycle later as wf_en=1, wf_wa=rd, wf_wd=data, held for one cycle; wf_en SHALL be 0 in all other cycles.
REQ-017 An accepted request with rd=0 SHALL be consumed but SHALL produce wf_en=0 and no scoreboard change.
REQ-018 The block SHALL accept back-to-back requests (one per cycle) with no bubble.
REQ-019 Scoreboard: pending[31:0] SHALL have bit 0 hardwired to 0.
REQ-020 An issue handshake (issue_valid & issue_ready) with rd!=0 SHALL set pending[rd] at the clock edge.
REQ-021 pending[wf_wa] SHALL clear at the edge ending a cycle with wf_en=1, which is the same edge the register file captures the data.
REQ-022 issue_ready SHALL be 1 if issue_rd=0 or pending[issue_rd]=0, and 0 otherwise; WAW issue SHALL stall.
REQ-023 If an issue and a commit of the same rd occur in one cycle, issue_ready SHALL still be 0 (pending set) and the clear SHALL take effect; issue SHALL proceed next cycle.
REQ-024 If an issue and a commit of different registers occur in one cycle, both SHALL take effect.
REQ-025 busy1 SHALL equal pending[adr1] and busy2 SHALL equal pending[adr2], combinationally; both SHALL be 0 for address 0.
REQ-026 A commit in cycle N SHALL leave busy=0 from cycle N+1, when register-file reads return the new data.

Reset
REQ-027 While RST_N=0, ready SHALL be 0, wf_en/wf_wa/wf_wd SHALL be 0, pending SHALL be all 0, busy1/busy2 SHALL be 0, and the RR pointer SHALL be 2 (so requester 0 wins first).
REQ-028 Assertion of reset mid-operation SHALL immediately drop any registered write (wf_en=0) and clear all pending bits; the write SHALL be lost.
REQ-029 Outputs SHALL respond to reset assertion without a clock edge; the first grant SHALL be possible in the first cycle after deassertion.

Verification
REQ-030 The bench SHALL cover: valid=3'b111 held, RR_EN=1 -> grants 0,1,2,0 on consecutive cycles; wf_wa follows rd0,rd1,rd2 one cycle later.
REQ-031 The bench SHALL cover: RR_EN=0, valid=3'b110 -> ready=3'b010 every cycle until valid[1] drops.
REQ-032 The bench SHALL cover: issue rd=5, then adr1=5 -> busy1=1; LOAD writes rd5=0xDEADBEEF -> wf_en=1 with wf_wd=0xDEADBEEF, then busy1=0 the next cycle.
REQ-033 The bench SHALL cover: pending[7]=1 and issue rd=7 -> issue_ready=0; the commit of rd7 clears it; issue is accepted the next cycle.
REQ-034 The bench SHALL cover: request with rd0=0, data=0x1234 -> ready=1 and wf_en stays 0.
REQ-035 The bench SHALL cover: accept a request, assert RST_N=0 before the next edge -> wf_en=0 and pending=0 immediately, with no register-file write.
